// File: rtl/branch_resolve_unit.sv
// Branch resolve unit: filters branch FU outcomes against the mispredict being broadcast,
// picks the oldest live mispredict, and registers the resolve mask plus saturating statistics.
`ifndef B_MASK_WIDTH
`define B_MASK_WIDTH 4
`endif

module branch_resolve_unit #(
    parameter int NUM_BR_FU    = 2,
    parameter int B_MASK_WIDTH = `B_MASK_WIDTH,
    parameter int CNT_WIDTH    = 32
) (
    input  logic                                      clock,
    input  logic                                      reset,
    input  logic [NUM_BR_FU-1:0]                      br_valid,
    input  logic [NUM_BR_FU-1:0][B_MASK_WIDTH-1:0]    br_bmm,
    input  logic [NUM_BR_FU-1:0][B_MASK_WIDTH-1:0]    br_bm,
    input  logic [NUM_BR_FU-1:0]                      br_mispred,
    output logic [B_MASK_WIDTH-1:0]                   b_mm_resolve,
    output logic                                      b_mm_mispred,
    output logic [CNT_WIDTH-1:0]                      resolve_count,
    output logic [CNT_WIDTH-1:0]                      mispred_count
);

    localparam int PC_W  = $clog2(B_MASK_WIDTH + 1);
    localparam int SUM_W = CNT_WIDTH + PC_W;
    localparam int MC_W  = CNT_WIDTH + 1;
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

    logic [B_MASK_WIDTH-1:0] r_resolve;
    logic                    r_mispred;
    logic [CNT_WIDTH-1:0]    r_resolve_count;
    logic [CNT_WIDTH-1:0]    r_mispred_count;

    logic [NUM_BR_FU-1:0]    w_live;
    logic [NUM_BR_FU-1:0]    w_cand;
    logic [NUM_BR_FU-1:0]    w_blocked;
    logic                    w_found;
    logic [B_MASK_WIDTH-1:0] w_win_bmm;
    logic [B_MASK_WIDTH-1:0] w_res_n;
    logic                    w_mis_n;
    logic [PC_W-1:0]         w_popcnt;
    logic [SUM_W-1:0]        w_rc_sum;
    logic [MC_W-1:0]         w_mc_sum;
    logic [CNT_WIDTH-1:0]    w_rc_next;
    logic [CNT_WIDTH-1:0]    w_mc_next;

    // Outcomes of branches that depend on the mispredict now being broadcast are squashed.
    always_comb begin
        w_live = '0;
        for (int i = 0; i < NUM_BR_FU; i++) begin
            w_live[i] = br_valid[i] && (br_bmm[i] != '0) &&
                        !(r_mispred && ((br_bm[i] & r_resolve) != '0));
        end
        w_cand = w_live & br_mispred;
    end

    // A candidate is blocked by an older candidate, or by a lower-index one owning the same bit.
    always_comb begin
        w_blocked = '0;
        w_found   = 1'b0;
        w_win_bmm = '0;
        for (int j = 0; j < NUM_BR_FU; j++) begin
            for (int k = 0; k < NUM_BR_FU; k++) begin
                if (k != j && w_cand[k] &&
                    (((br_bm[j] & br_bmm[k]) != '0) || ((br_bmm[k] == br_bmm[j]) && (k < j)))) begin
                    w_blocked[j] = 1'b1;
                end
            end
        end
        for (int j = 0; j < NUM_BR_FU; j++) begin
            if (w_cand[j] && !w_blocked[j] && !w_found) begin
                w_found   = 1'b1;
                w_win_bmm = br_bmm[j];
            end
        end
    end

    always_comb begin
        w_res_n = '0;
        for (int k = 0; k < NUM_BR_FU; k++) begin
            if (w_found) begin
                if (w_live[k] && !br_mispred[k] && ((br_bm[k] & w_win_bmm) == '0)) begin
                    w_res_n = w_res_n | br_bmm[k];
                end
            end else if (w_live[k]) begin
                w_res_n = w_res_n | br_bmm[k];
            end
        end
        if (w_found) begin
            w_res_n = w_res_n | w_win_bmm;
        end
        w_mis_n = w_found;
    end

    always_comb begin
        w_popcnt = '0;
        for (int i = 0; i < B_MASK_WIDTH; i++) begin
            w_popcnt = w_popcnt + PC_W'(w_res_n[i]);
        end
        w_rc_sum  = SUM_W'(r_resolve_count) + SUM_W'(w_popcnt);
        w_mc_sum  = MC_W'(r_mispred_count) + MC_W'(w_mis_n);
        w_rc_next = (w_rc_sum > SUM_W'(CNT_MAX)) ? CNT_MAX : w_rc_sum[CNT_WIDTH-1:0];
        w_mc_next = (w_mc_sum > MC_W'(CNT_MAX)) ? CNT_MAX : w_mc_sum[CNT_WIDTH-1:0];
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_resolve       <= '0;
            r_mispred       <= 1'b0;
            r_resolve_count <= '0;
            r_mispred_count <= '0;
        end else begin
            r_resolve       <= w_res_n;
            r_mispred       <= w_mis_n;
            r_resolve_count <= w_rc_next;
            r_mispred_count <= w_mc_next;
        end
    end

    assign b_mm_resolve  = r_resolve;
    assign b_mm_mispred  = r_mispred;
    assign resolve_count = r_resolve_count;
    assign mispred_count = r_mispred_count;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Bench for branch_resolve_unit: a 32-bit-counter instance and a 2-bit-counter instance share
// stimulus; an age-based reference model predicts outputs into a queue drained by a monitor.
module tb_branch_resolve_unit;
    localparam int EXP_W = 73;

    logic                  clock = 1'b0;
    logic                  reset = 1'b0;
    logic [1:0]            br_valid = '0;
    logic [1:0][3:0]       br_bmm = '0;
    logic [1:0][3:0]       br_bm = '0;
    logic [1:0]            br_mispred = '0;

    logic [3:0]            b_mm_resolve, s_mm_resolve;
    logic                  b_mm_mispred, s_mm_mispred;
    logic [31:0]           resolve_count, mispred_count;
    logic [1:0]            s_resolve_count, s_mispred_count;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [EXP_W-1:0] exp_q[$];

    // Model state: the outputs the DUT should currently present.
    logic [3:0] m_res = '0;
    logic       m_mis = 1'b0;
    longint     m_rc = 0, m_mc = 0, m_rc2 = 0, m_mc2 = 0;

    branch_resolve_unit #(.NUM_BR_FU(2), .B_MASK_WIDTH(4), .CNT_WIDTH(32)) u_dut (
        .clock(clock), .reset(reset), .br_valid(br_valid), .br_bmm(br_bmm), .br_bm(br_bm),
        .br_mispred(br_mispred), .b_mm_resolve(b_mm_resolve), .b_mm_mispred(b_mm_mispred),
        .resolve_count(resolve_count), .mispred_count(mispred_count)
    );

    branch_resolve_unit #(.NUM_BR_FU(2), .B_MASK_WIDTH(4), .CNT_WIDTH(2)) u_sat (
        .clock(clock), .reset(reset), .br_valid(br_valid), .br_bmm(br_bmm), .br_bm(br_bm),
        .br_mispred(br_mispred), .b_mm_resolve(s_mm_resolve), .b_mm_mispred(s_mm_mispred),
        .resolve_count(s_resolve_count), .mispred_count(s_mispred_count)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_out(input string name, input logic [3:0] res, input logic mis,
                             input longint rc, input longint mc, input longint rc2, input longint mc2);
        check({name, ".resolve"}, 64'(b_mm_resolve), 64'(res));
        check({name, ".mispred"}, 64'(b_mm_mispred), 64'(mis));
        check({name, ".resolve_count"}, 64'(resolve_count), 64'(rc));
        check({name, ".mispred_count"}, 64'(mispred_count), 64'(mc));
        check({name, ".sat_resolve_count"}, 64'(s_resolve_count), 64'(rc2));
        check({name, ".sat_mispred_count"}, 64'(s_mispred_count), 64'(mc2));
    endtask

    // age = position in program order (0 = oldest); the model ranks branches by it.
    task automatic drive(input logic [1:0] v, input logic [3:0] bmm0, input logic [3:0] bm0,
                         input logic [3:0] bmm1, input logic [3:0] bm1, input logic [1:0] mis,
                         input int age0, input int age1);
        logic [3:0] bmm[2];
        logic [3:0] bm[2];
        int         age[2];
        logic       live[2];
        logic [3:0] res;
        int         w;
        @(negedge clock);
        br_valid   = v;
        br_bmm[0]  = bmm0;
        br_bmm[1]  = bmm1;
        br_bm[0]   = bm0;
        br_bm[1]   = bm1;
        br_mispred = mis;
        bmm[0] = bmm0; bmm[1] = bmm1;
        bm[0]  = bm0;  bm[1]  = bm1;
        age[0] = age0; age[1] = age1;
        w   = -1;
        res = '0;
        for (int i = 0; i < 2; i++) begin
            live[i] = v[i] && (bmm[i] != 0) && !(m_mis && ((bm[i] & m_res) != 0));
            if (live[i] && mis[i] && (w < 0 || age[i] < age[w])) w = i;
        end
        if (w >= 0) begin
            res = bmm[w];
            for (int k = 0; k < 2; k++) begin
                if (live[k] && !mis[k] && age[k] < age[w]) res = res | bmm[k];
            end
        end else begin
            for (int k = 0; k < 2; k++) if (live[k]) res = res | bmm[k];
        end
        m_res = res;
        m_mis = (w >= 0);
        m_rc  = m_rc + $countones(res);
        if (m_rc > 64'h0000_0000_FFFF_FFFF) m_rc = 64'h0000_0000_FFFF_FFFF;
        m_rc2 = m_rc2 + $countones(res);
        if (m_rc2 > 3) m_rc2 = 3;
        if (m_mis) begin
            if (m_mc < 64'h0000_0000_FFFF_FFFF) m_mc = m_mc + 1;
            if (m_mc2 < 3) m_mc2 = m_mc2 + 1;
        end
        exp_q.push_back({m_res, m_mis, m_rc[31:0], m_mc[31:0], m_rc2[1:0], m_mc2[1:0]});
    endtask

    // Legal random stimulus: a random program order of the four stack bits, each FU at a distinct slot.
    task automatic rand_cycle();
        int         perm[4];
        int         pos[2];
        int         j, t;
        logic [3:0] one;
        logic [3:0] bmm[2];
        logic [3:0] bm[2];
        logic [1:0] v, mis;
        one = 4'b0001;
        for (int i = 0; i < 4; i++) perm[i] = i;
        for (int i = 3; i > 0; i--) begin
            j = $urandom_range(0, i);
            t = perm[i]; perm[i] = perm[j]; perm[j] = t;
        end
        pos[0] = $urandom_range(0, 3);
        pos[1] = $urandom_range(0, 2);
        if (pos[1] >= pos[0]) pos[1] = pos[1] + 1;
        for (int f = 0; f < 2; f++) begin
            bmm[f] = one << perm[pos[f]];
            bm[f]  = '0;
            for (int p = 0; p < pos[f]; p++) bm[f] = bm[f] | (one << perm[p]);
        end
        for (int f = 0; f < 2; f++) begin
            if ($urandom_range(0, 3) == 0) bm[f] = bm[f] & ~(4'($urandom) & ~bmm[1-f]);
        end
        for (int f = 0; f < 2; f++) if ($urandom_range(0, 15) == 0) bmm[f] = '0;
        v   = 2'($urandom);
        mis = {($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0)};
        drive(v, bmm[0], bm[0], bmm[1], bm[1], mis, pos[0], pos[1]);
    endtask

    always @(posedge clock) begin
        logic [EXP_W-1:0] e;
        #1;
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("mon.resolve", 64'(b_mm_resolve), 64'(e[72:69]));
            check("mon.mispred", 64'(b_mm_mispred), 64'(e[68]));
            check("mon.resolve_count", 64'(resolve_count), 64'(e[67:36]));
            check("mon.mispred_count", 64'(mispred_count), 64'(e[35:4]));
            check("mon.sat_resolve_count", 64'(s_resolve_count), 64'(e[3:2]));
            check("mon.sat_mispred_count", 64'(s_mispred_count), 64'(e[1:0]));
            check("mon.sat_resolve", 64'(s_mm_resolve), 64'(e[72:69]));
        end
    end

    initial begin
        repeat (3) @(posedge clock);
        #2;
        check_out("reset_held", 4'b0000, 1'b0, 0, 0, 0, 0);
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
        #2;
        check_out("after_release", 4'b0000, 1'b0, 0, 0, 0, 0);

        drive(2'b11, 4'b0001, 4'b0000, 4'b0100, 4'b0001, 2'b00, 0, 1);
        @(posedge clock); #2;
        check_out("dual_correct", 4'b0101, 1'b0, 2, 0, 2, 0);

        drive(2'b11, 4'b0010, 4'b0001, 4'b0100, 4'b0011, 2'b01, 1, 2);
        @(posedge clock); #2;
        check_out("older_mispred", 4'b0010, 1'b1, 3, 1, 3, 1);

        drive(2'b01, 4'b1000, 4'b0010, 4'b0000, 4'b0000, 2'b00, 2, 3);
        @(posedge clock); #2;
        check_out("post_mispred_filter", 4'b0000, 1'b0, 3, 1, 3, 1);

        drive(2'b11, 4'b0001, 4'b0000, 4'b1000, 4'b0001, 2'b10, 0, 1);
        @(posedge clock); #2;
        check_out("younger_mispred", 4'b1001, 1'b1, 5, 2, 3, 2);

        drive(2'b11, 4'b0100, 4'b0010, 4'b0010, 4'b0000, 2'b11, 1, 0);
        @(posedge clock); #2;
        check_out("dual_mispred", 4'b0010, 1'b1, 6, 3, 3, 3);

        // Asynchronous reset mid-cycle while 0010 / 1 is presented.
        #1;
        reset      = 1'b0;
        br_valid   = '0;
        br_bmm     = '0;
        br_bm      = '0;
        br_mispred = '0;
        #1;
        check_out("async_reset", 4'b0000, 1'b0, 0, 0, 0, 0);
        exp_q.delete();
        m_res = '0; m_mis = 1'b0; m_rc = 0; m_mc = 0; m_rc2 = 0; m_mc2 = 0;
        repeat (2) @(negedge clock);
        reset = 1'b1;

        drive(2'b00, 4'b0001, 4'b0000, 4'b0010, 4'b0001, 2'b00, 0, 1);
        @(posedge clock); #2;
        check_out("empty_cycle", 4'b0000, 1'b0, 0, 0, 0, 0);

        for (int i = 0; i < 5; i++) begin
            drive(2'b11, 4'b0001, 4'b0000, 4'b0100, 4'b0001, 2'b00, 0, 1);
            @(posedge clock); #2;
            check_out("saturation", 4'b0101, 1'b0, 2 * (i + 1), 0, (i == 0) ? 2 : 3, 0);
        end

        repeat (400) rand_cycle();

        repeat (2) @(posedge clock);
        #3;
        check("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
